// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU select encoding, RV32I opcode/funct constants and decode helpers
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int SEL_W = 11;

    typedef logic [SEL_W-1:0] alu_sel_t;

    // Bit positions within the one-hot ALU select
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SRA  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt picks sub over add and sra over srl; ignored for the other funct3 codes
    function automatic logic [3:0] f3_index(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  f3_index = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  f3_index = ALU_SLL;
            F3_SLT:  f3_index = ALU_SLT;
            F3_SLTU: f3_index = ALU_SLTU;
            F3_XOR:  f3_index = ALU_XOR;
            F3_SR:   f3_index = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   f3_index = ALU_OR;
            default: f3_index = ALU_AND;
        endcase
    endfunction

    function automatic alu_sel_t sel_onehot(input logic [3:0] idx);
        sel_onehot = alu_sel_t'(1) << idx;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - per-register busy bits with writeback bypass for two read ports
module id_scoreboard (
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  logic       set_en,
    input  logic [4:0] set_addr,
    input  logic       clr_en,
    input  logic [4:0] clr_addr,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    output logic       rs1_busy,
    output logic       rs2_busy
);

    logic [31:0] busy;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] busy_eff;
    logic [31:0] busy_nxt;

    always_comb begin
        set_mask = set_en ? (32'd1 << set_addr) : 32'd0;
        clr_mask = clr_en ? (32'd1 << clr_addr) : 32'd0;
        busy_eff = busy & ~clr_mask;
        // set is applied after clear so a same-cycle retire/reissue of one register stays busy
        busy_nxt = (busy_eff | set_mask) & ~32'd1;
        rs1_busy = busy_eff[rs1_addr];
        rs2_busy = busy_eff[rs2_addr];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/id_alu_issue.sv
// rtl/id_alu_issue.sv - RV32I ALU-class decode/issue stage; ID_PERF_CNT_EN adds issue/stall counters
module id_alu_issue #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 11
`ifdef ID_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_inst,
    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    input  logic [XLEN-1:0]  rf_rdata1,
    input  logic [XLEN-1:0]  rf_rdata2,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [SEL_W-1:0] ex_alu_sel,
    output logic [XLEN-1:0]  ex_src1,
    output logic [XLEN-1:0]  ex_src2,
    output logic [4:0]       ex_rd,
    output logic             ex_we,
    output logic [XLEN-1:0]  ex_pc,
    output logic             ex_illegal,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush
`ifdef ID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_issue_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    import alu_pkg::*;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode    = in_inst[6:0];
    assign rd        = in_inst[11:7];
    assign funct3    = in_inst[14:12];
    assign funct7    = in_inst[31:25];
    assign rf_raddr1 = in_inst[19:15];
    assign rf_raddr2 = in_inst[24:20];

    logic [SEL_W-1:0] dec_sel;
    logic [XLEN-1:0]  dec_src1;
    logic [XLEN-1:0]  dec_src2;
    logic             dec_illegal;
    logic             dec_we;
    logic             rs1_used;
    logic             rs2_used;

    always_comb begin
        dec_sel     = '0;
        dec_src1    = '0;
        dec_src2    = '0;
        dec_illegal = 1'b0;
        rs1_used    = 1'b0;
        rs2_used    = 1'b0;
        case (opcode)
            OPC_OP: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                dec_src1 = rf_rdata1;
                dec_src2 = rf_rdata2;
                if (funct7 == F7_BASE)
                    dec_sel = sel_onehot(f3_index(funct3, 1'b0));
                else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR))
                    dec_sel = sel_onehot(f3_index(funct3, 1'b1));
                else
                    dec_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                rs1_used = 1'b1;
                dec_src1 = rf_rdata1;
                if (funct3 == F3_SLL || funct3 == F3_SR) begin
                    dec_src2 = {27'd0, in_inst[24:20]};
                    if (funct7 == F7_BASE)
                        dec_sel = sel_onehot(f3_index(funct3, 1'b0));
                    else if (funct7 == F7_ALT && funct3 == F3_SR)
                        dec_sel = sel_onehot(ALU_SRA);
                    else
                        dec_illegal = 1'b1;
                end else begin
                    // immediate bit 30 is data here, never an alternate-op flag
                    dec_src2 = {{20{in_inst[31]}}, in_inst[31:20]};
                    dec_sel  = sel_onehot(f3_index(funct3, 1'b0));
                end
            end
            OPC_LUI: begin
                dec_sel  = sel_onehot(ALU_LUI);
                dec_src2 = {12'd0, in_inst[31:12]};
            end
            OPC_AUIPC: begin
                dec_sel  = sel_onehot(ALU_ADD);
                dec_src1 = in_pc;
                dec_src2 = {in_inst[31:12], 12'd0};
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_sel  = '0;
            dec_src1 = '0;
            dec_src2 = '0;
        end
    end

    assign dec_we = ~dec_illegal & (rd != 5'd0);

    logic rs1_busy;
    logic rs2_busy;
    logic raw_stall;
    logic fire;

    id_scoreboard u_scoreboard (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .set_en   (fire & dec_we),
        .set_addr (rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .rs1_addr (rf_raddr1),
        .rs2_addr (rf_raddr2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

    assign raw_stall = (rs1_used & rs1_busy) | (rs2_used & rs2_busy);
    assign in_ready  = (~ex_valid | ex_ready) & ~raw_stall & ~flush;
    assign fire      = in_valid & in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid   <= 1'b0;
            ex_alu_sel <= '0;
            ex_src1    <= '0;
            ex_src2    <= '0;
            ex_rd      <= '0;
            ex_we      <= 1'b0;
            ex_pc      <= '0;
            ex_illegal <= 1'b0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_alu_sel <= '0;
        end else if (fire) begin
            ex_valid   <= 1'b1;
            ex_alu_sel <= dec_sel;
            ex_src1    <= dec_src1;
            ex_src2    <= dec_src2;
            ex_rd      <= rd;
            ex_we      <= dec_we;
            ex_pc      <= in_pc;
            ex_illegal <= dec_illegal;
        end else if (ex_valid && ex_ready) begin
            // an empty slot must present an all-zero select
            ex_valid   <= 1'b0;
            ex_alu_sel <= '0;
        end
    end

`ifdef ID_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fire)
                perf_issue_cnt <= perf_issue_cnt + CNT_W'(1);
            if (in_valid && raw_stall)
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_id_alu_issue.sv
// tb/tb_id_alu_issue.sv - directed self-checking bench for id_alu_issue
module tb_id_alu_issue;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        ex_valid;
    logic        ex_ready;
    logic [10:0] ex_alu_sel;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic [31:0] ex_pc;
    logic        ex_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
`ifdef ID_PERF_CNT_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    id_alu_issue dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_alu_sel (ex_alu_sel),
        .ex_src1    (ex_src1),
        .ex_src2    (ex_src2),
        .ex_rd      (ex_rd),
        .ex_we      (ex_we),
        .ex_pc      (ex_pc),
        .ex_illegal (ex_illegal),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush)
`ifdef ID_PERF_CNT_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd);
        r_type = {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd);
        i_type = {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                           input logic [6:0] opc);
        u_type = {imm, rd, opc};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; ex_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
        tick; tick;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_sel", 32'(ex_alu_sel), 32'd0);
        chk("rst_src1", ex_src1, 32'd0);
        chk("rst_we", 32'(ex_we), 32'd0);
        chk("rst_illegal", 32'(ex_illegal), 32'd0);
        resetn = 1'b1;

        // add x3,x1,x2
        in_valid = 1'b1; in_pc = 32'h100; in_inst = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        rf_rdata1 = 32'd5; rf_rdata2 = 32'd7; #1;
        chk("add_in_ready", 32'(in_ready), 32'd1);
        chk("add_raddr1", 32'(rf_raddr1), 32'd1);
        chk("add_raddr2", 32'(rf_raddr2), 32'd2);
        tick;
        chk("add_valid", 32'(ex_valid), 32'd1);
        chk("add_sel", 32'(ex_alu_sel), 32'h001);
        chk("add_src1", ex_src1, 32'd5);
        chk("add_src2", ex_src2, 32'd7);
        chk("add_rd", 32'(ex_rd), 32'd3);
        chk("add_we", 32'(ex_we), 32'd1);
        chk("add_pc", ex_pc, 32'h100);

        // sub x4,x1,x2
        in_pc = 32'h104; in_inst = r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
        rf_rdata1 = 32'd9; rf_rdata2 = 32'd4;
        tick;
        chk("sub_sel", 32'(ex_alu_sel), 32'h002);
        chk("sub_src1", ex_src1, 32'd9);
        chk("sub_rd", 32'(ex_rd), 32'd4);

        // srai x1,x2,4
        in_inst = i_type(12'h404, 5'd2, 3'b101, 5'd1); rf_rdata1 = 32'h80;
        tick;
        chk("srai_sel", 32'(ex_alu_sel), 32'h020);
        chk("srai_src1", ex_src1, 32'h80);
        chk("srai_src2", ex_src2, 32'd4);

        // lui x5,0xABCDE
        in_inst = u_type(20'hABCDE, 5'd5, 7'b0110111);
        tick;
        chk("lui_sel", 32'(ex_alu_sel), 32'h400);
        chk("lui_src1", ex_src1, 32'd0);
        chk("lui_src2", ex_src2, 32'h000ABCDE);

        // auipc x6,0x1
        in_pc = 32'h80000000; in_inst = u_type(20'h00001, 5'd6, 7'b0010111);
        tick;
        chk("auipc_sel", 32'(ex_alu_sel), 32'h001);
        chk("auipc_src1", ex_src1, 32'h80000000);
        chk("auipc_src2", ex_src2, 32'h00001000);
        chk("auipc_pc", ex_pc, 32'h80000000);

        // addi x7,x0,-1
        in_inst = i_type(12'hFFF, 5'd0, 3'b000, 5'd7); rf_rdata1 = 32'd0;
        tick;
        chk("addi_neg_sel", 32'(ex_alu_sel), 32'h001);
        chk("addi_neg_src2", ex_src2, 32'hFFFFFFFF);

        // addi x9,x2,0x400: imm bit 30 set must still mean add
        in_inst = i_type(12'h400, 5'd2, 3'b000, 5'd9); rf_rdata1 = 32'd3;
        tick;
        chk("addi_b30_sel", 32'(ex_alu_sel), 32'h001);
        chk("addi_b30_src2", ex_src2, 32'h400);

        // bad opcode
        in_inst = 32'h0000007F;
        tick;
        chk("ill_opc_valid", 32'(ex_valid), 32'd1);
        chk("ill_opc_flag", 32'(ex_illegal), 32'd1);
        chk("ill_opc_sel", 32'(ex_alu_sel), 32'd0);
        chk("ill_opc_we", 32'(ex_we), 32'd0);

        // slli x8,x2,3 with funct7=0100000
        in_inst = i_type(12'h403, 5'd2, 3'b001, 5'd8);
        tick;
        chk("ill_slli_flag", 32'(ex_illegal), 32'd1);
        chk("ill_slli_sel", 32'(ex_alu_sel), 32'd0);
        chk("ill_slli_we", 32'(ex_we), 32'd0);

        // flush with ex_valid=1 and x3/x4 busy
        in_valid = 1'b0; flush = 1'b1; #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick;
        flush = 1'b0;
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_sel", 32'(ex_alu_sel), 32'd0);
        in_valid = 1'b1; in_inst = r_type(7'h00, 5'd4, 5'd3, 3'b000, 5'd10); #1;
        chk("flush_sb_clear", 32'(in_ready), 32'd1);
        tick;

        // RAW: add x3,x1,x2 then add x3,x3,x3
        in_inst = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        tick;
        in_inst = r_type(7'h00, 5'd3, 5'd3, 3'b000, 5'd3); #1;
        chk("raw_stall", 32'(in_ready), 32'd0);
        tick;
        chk("raw_drain_valid", 32'(ex_valid), 32'd0);
        chk("raw_drain_sel", 32'(ex_alu_sel), 32'd0);
        chk("raw_still_stall", 32'(in_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd3; rf_rdata1 = 32'h11; rf_rdata2 = 32'h11; #1;
        chk("raw_wb_bypass", 32'(in_ready), 32'd1);
        tick;
        wb_valid = 1'b0;
        chk("raw_issue_valid", 32'(ex_valid), 32'd1);
        chk("raw_issue_rd", 32'(ex_rd), 32'd3);
        chk("raw_issue_src1", ex_src1, 32'h11);
        in_inst = r_type(7'h00, 5'd0, 5'd3, 3'b000, 5'd5); #1;
        chk("set_wins", 32'(in_ready), 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd3; #1;
        chk("set_wins_release", 32'(in_ready), 32'd1);
        tick;
        wb_valid = 1'b0;
        chk("x5_rd", 32'(ex_rd), 32'd5);

        // backpressure
        ex_ready = 1'b0; in_inst = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd11);
        rf_rdata1 = 32'd1; rf_rdata2 = 32'd2; #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("bp_hold_valid_%0d", i), 32'(ex_valid), 32'd1);
            chk($sformatf("bp_hold_rd_%0d", i), 32'(ex_rd), 32'd5);
            chk($sformatf("bp_hold_src1_%0d", i), ex_src1, 32'h11);
            chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
        end
        ex_ready = 1'b1; #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick;
        chk("b2b_rd11", 32'(ex_rd), 32'd11);
        chk("b2b_src1", ex_src1, 32'd1);
        in_inst = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd12);
        tick;
        chk("b2b_rd12", 32'(ex_rd), 32'd12);
        chk("b2b_valid", 32'(ex_valid), 32'd1);

        // asynchronous reset while stalled on x12
        in_inst = r_type(7'h00, 5'd0, 5'd12, 3'b000, 5'd13); #1;
        chk("pre_rst_stall", 32'(in_ready), 32'd0);
        #1 resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_sel", 32'(ex_alu_sel), 32'd0);
        chk("arst_src1", ex_src1, 32'd0);
        chk("arst_src2", ex_src2, 32'd0);
        chk("arst_pc", ex_pc, 32'd0);
        chk("arst_rd", 32'(ex_rd), 32'd0);
        chk("arst_we", 32'(ex_we), 32'd0);
`ifdef ID_PERF_CNT_EN
        chk("arst_perf_issue", perf_issue_cnt, 32'd0);
        chk("arst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        resetn = 1'b1; #1;
        chk("post_rst_sb_clear", 32'(in_ready), 32'd1);

        // one fire, two stall cycles, then a second fire in the wb cycle
        tick;
        in_inst = r_type(7'h00, 5'd0, 5'd13, 3'b000, 5'd14);
        tick;
        tick;
        wb_valid = 1'b1; wb_rd = 5'd13;
        tick;
        wb_valid = 1'b0; in_valid = 1'b0;
        chk("cnt_seq_rd", 32'(ex_rd), 32'd14);
`ifdef ID_PERF_CNT_EN
        chk("perf_issue", perf_issue_cnt, 32'd2);
        chk("perf_stall", perf_stall_cnt, 32'd2);
`endif
        tick;
        chk("final_drain", 32'(ex_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
